// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each granted access runs IDLE -> SETUP -> STROBE -> DONE with a one-cycle memory strobe.
module data_mem_arbiter #(
    parameter int AB = 11,
    parameter int DB = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AB-1:0] addr0,
    input  logic [AB-1:0] addr1,
    input  logic [DB-1:0] wdata0,
    input  logic [DB-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DB-1:0] rdata0,
    output logic [DB-1:0] rdata1,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AB-1:0] mem_addr,
    output logic [DB-1:0] mem_wdata,
    input  logic [DB-1:0] mem_rdata,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    // Handshake: reqN is a level held with weN/addrN/wdataN stable until it is
    // sampled in IDLE; completion is the one-cycle ackN pulse, which is issued
    // even if reqN was dropped after sampling. Requests are only sampled in IDLE.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last_grant;
    logic          cur_port;
    logic          cur_we;
    logic [AB-1:0] addr_q;
    logic [DB-1:0] wdata_q;
    logic          grant_any;
    logic          grant_port;

    always_comb begin
        grant_any  = req0 | req1;
        grant_port = 1'b0;
        // On a tie the port that did not win last time gets the grant.
        if (req0 && req1) begin
            grant_port = ~last_grant;
        end else begin
            grant_port = req1;
        end

        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = SETUP;
            SETUP:   state_nxt = STROBE;
            STROBE:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cur_port   <= 1'b0;
            cur_we     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_any) begin
                cur_port   <= grant_port;
                last_grant <= grant_port;
                cur_we     <= grant_port ? we1    : we0;
                addr_q     <= grant_port ? addr1  : addr0;
                wdata_q    <= grant_port ? wdata1 : wdata0;
            end
            if (state == STROBE && !cur_we) begin
                if (cur_port) begin
                    rdata1 <= mem_rdata;
                end else begin
                    rdata0 <= mem_rdata;
                end
            end
        end
    end

    // Strobes decode straight from state so an async reset removes them at once.
    always_comb begin
        mem_wr    = (state == STROBE) &&  cur_we;
        mem_rd    = (state == STROBE) && !cur_we;
        ack0      = (state == DONE) && !cur_port;
        ack1      = (state == DONE) &&  cur_port;
        busy      = (state != IDLE);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        dbg_state = state;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: single accesses, readback, input isolation,
// reset during STROBE and round-robin contention, against hand-computed values.
module tb_data_mem_arbiter;

    localparam int AB = 11;
    localparam int DB = 16;

    logic          clk;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AB-1:0] addr0, addr1;
    logic [DB-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [DB-1:0] rdata0, rdata1;
    logic          mem_rd, mem_wr;
    logic [AB-1:0] mem_addr;
    logic [DB-1:0] mem_wdata, mem_rdata;
    logic          busy;
    logic [1:0]    dbg_state;

    logic [DB-1:0] mem [0:(1<<AB)-1];
    logic [1:0]    exp_q[$];
    int            n_cmp;
    int            n_err;

    data_mem_arbiter #(.AB(AB), .DB(DB)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // memory model behind the arbiter
    initial begin
        for (int i = 0; i < (1 << AB); i++) mem[i] = '0;
    end
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic drive_port(input bit port, input logic rq, input logic we,
                              input logic [AB-1:0] addr, input logic [DB-1:0] wd);
        if (port) begin
            req1 = rq; we1 = we; addr1 = addr; wdata1 = wd;
        end else begin
            req0 = rq; we0 = we; addr0 = addr; wdata0 = wd;
        end
    endtask

    // Call right after a negedge with the DUT in IDLE. The request is dropped and
    // the port inputs scrambled during SETUP to show the transaction is latched.
    task automatic do_access(input bit port, input logic we, input logic [AB-1:0] addr,
                             input logic [DB-1:0] wd, input logic [DB-1:0] exp_rd,
                             input logic [DB-1:0] other_rd);
        drive_port(port, 1'b1, we, addr, wd);
        @(negedge clk);
        check("setup_busy", busy, 1);
        check("setup_state", dbg_state, 1);
        check("setup_strobes", {mem_rd, mem_wr}, 0);
        check("setup_ack", {ack1, ack0}, 0);
        drive_port(port, 1'b0, ~we, addr + AB'(4), ~wd);
        @(negedge clk);
        check("strobe_wr", mem_wr, we);
        check("strobe_rd", mem_rd, !we);
        check("strobe_addr", mem_addr, addr);
        check("strobe_wdata", mem_wdata, wd);
        check("strobe_ack", {ack1, ack0}, 0);
        @(negedge clk);
        check("done_ack", {ack1, ack0}, port ? 2'b10 : 2'b01);
        check("done_strobes", {mem_rd, mem_wr}, 0);
        check("done_addr", mem_addr, addr);
        check("done_rdata", port ? rdata1 : rdata0, exp_rd);
        check("done_other_rdata", port ? rdata0 : rdata1, other_rd);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_ack", {ack1, ack0}, 0);
        check("idle_addr_hold", mem_addr, addr);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(negedge clk);

        check("rst_state", dbg_state, 0);
        check("rst_busy", busy, 0);
        check("rst_strobes", {mem_rd, mem_wr}, 0);
        check("rst_acks", {ack1, ack0}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", {rdata1, rdata0}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_req", dbg_state, 0);

        // single write, readback from the other port, then port 0 round trip
        do_access(1'b0, 1'b1, AB'(5), 16'h3FC0, 16'h0000, 16'h0000);
        do_access(1'b1, 1'b0, AB'(5), 16'h1234, 16'h3FC0, 16'h0000);
        do_access(1'b0, 1'b1, AB'(9), 16'h00FF, 16'h0000, 16'h3FC0);
        do_access(1'b0, 1'b0, AB'(9), 16'h0000, 16'h00FF, 16'h3FC0);

        // reset while the write strobe is up
        drive_port(1'b0, 1'b1, 1'b1, AB'(20), 16'hABCD);
        @(negedge clk);
        drive_port(1'b0, 1'b0, 1'b0, AB'(0), 16'h0000);
        @(negedge clk);
        check("pre_rst_wr", mem_wr, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_strobes", {mem_rd, mem_wr}, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_state", dbg_state, 0);
        check("async_rst_addr", mem_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_no_ack", {ack1, ack0}, 0);
            check("post_rst_idle", busy, 0);
        end
        check("aborted_write", mem[20], 16'h0000);
        do_access(1'b0, 1'b0, AB'(5), 16'h0000, 16'h3FC0, 16'h0000);

        // contention from reset release: grants must alternate 0,1,0,1
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive_port(1'b0, 1'b1, 1'b1, AB'(30), 16'h5A5A);
        drive_port(1'b1, 1'b1, 1'b0, AB'(5), 16'h0000);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        for (int k = 1; k <= 16; k++) begin
            logic [1:0] exp_port;
            @(negedge clk);
            check($sformatf("rr_ack_c%0d", k), ack0 | ack1, (k % 4) == 3);
            check("rr_ack_excl", ack0 & ack1, 0);
            if (ack0 | ack1) begin
                exp_port = (exp_q.size() != 0) ? exp_q.pop_front() : 2'd2;
                check("rr_order", {1'b0, ack1}, exp_port);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        check("rr_all_granted", exp_q.size(), 0);
        check("rr_rdata1", rdata1, 16'h3FC0);
        check("rr_write_landed", mem[30], 16'h5A5A);
        check("rr_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
